// File: rtl/seg_scan_drv_if.sv
// Display bus for seg_scan_drv: value/point/sign/enable towards the driver,
// registered digit select and segment lines back from it.
interface seg_scan_drv_if;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign;
  logic        seg_en;
  logic [5:0]  sel;
  logic [7:0]  seg;

  modport master (output data, point, sign, seg_en, input sel, seg);
  modport slave  (input data, point, sign, seg_en, output sel, seg);
endinterface

// File: rtl/seg_scan_drv.sv
// Six-digit multiplexed 7-segment driver with sequential binary-to-BCD conversion.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the significant part.
module seg_scan_drv #(
  parameter logic [15:0] CNT_MAX = 16'd49_999
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  seg_scan_drv_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  localparam logic [19:0] DATA_MAX = 20'd999_999;

  logic [15:0] cnt_q;
  logic [2:0]  idx_q;

  state_e      state_q,      state_d;
  logic [19:0] bin_q,        bin_d;
  logic [23:0] bcd_q,        bcd_d;
  logic [4:0]  shift_cnt_q,  shift_cnt_d;
  logic [19:0] last_q,       last_d;
  logic [5:0]  smp_point_q,  smp_point_d;
  logic        smp_sign_q,   smp_sign_d;
  logic [23:0] disp_bcd_q,   disp_bcd_d;
  logic [5:0]  disp_point_q, disp_point_d;
  logic        disp_sign_q,  disp_sign_d;

  logic [5:0]  sel_q;
  logic [7:0]  seg_q;

  logic [23:0] bcd_adj;
  logic [43:0] shift_w;

  // Scan timebase: one digit per CNT_MAX+1 cycles, digit index 0..5.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt_q <= 16'd0;
      idx_q <= 3'd0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q <= 16'd0;
      idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end else begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < 6; i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                     : bcd_q[4*i +: 4];
    end
  end

  assign shift_w = {bcd_adj, bin_q} << 1;

  // NOTE: every output of this block gets its hold value first, so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    shift_cnt_d  = shift_cnt_q;
    last_d       = last_q;
    smp_point_d  = smp_point_q;
    smp_sign_d   = smp_sign_q;
    disp_bcd_d   = disp_bcd_q;
    disp_point_d = disp_point_q;
    disp_sign_d  = disp_sign_q;
    case (state_q)
      IDLE: begin
        if (bus.data != last_q) begin
          last_d      = bus.data;
          bin_d       = (bus.data > DATA_MAX) ? DATA_MAX : bus.data;
          bcd_d       = 24'd0;
          shift_cnt_d = 5'd0;
          smp_point_d = bus.point;
          smp_sign_d  = bus.sign;
          state_d     = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d       = shift_w[43:20];
        bin_d       = shift_w[19:0];
        shift_cnt_d = shift_cnt_q + 5'd1;
        if (shift_cnt_q == 5'd19) state_d = DONE;
      end
      DONE: begin
        disp_bcd_d   = bcd_q;
        disp_point_d = smp_point_q;
        disp_sign_d  = smp_sign_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: display registers are reset too, so the panel shows a defined value before the first conversion.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      bin_q        <= 20'd0;
      bcd_q        <= 24'd0;
      shift_cnt_q  <= 5'd0;
      last_q       <= 20'd0;
      smp_point_q  <= 6'd0;
      smp_sign_q   <= 1'b0;
      disp_bcd_q   <= 24'd0;
      disp_point_q <= 6'd0;
      disp_sign_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bin_q        <= bin_d;
      bcd_q        <= bcd_d;
      shift_cnt_q  <= shift_cnt_d;
      last_q       <= last_d;
      smp_point_q  <= smp_point_d;
      smp_sign_q   <= smp_sign_d;
      disp_bcd_q   <= disp_bcd_d;
      disp_point_q <= disp_point_d;
      disp_sign_q  <= disp_sign_d;
    end
  end

  logic [2:0] msd;
  logic [2:0] minus_pos;
  logic       minus_vld;
  logic       blank;
  logic [3:0] cur_nib;
  logic [7:0] cur_code;
`ifdef LEADING_ZERO_BLANK_EN
  logic [2:0] hp;
  logic       hp_vld;
`endif

  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < 6; i++) begin
      if (disp_bcd_q[4*i +: 4] != 4'd0) msd = 3'(i);
    end
    // A six-digit value leaves no room for the minus sign.
    minus_vld = disp_sign_q && (msd != 3'd5);
`ifdef LEADING_ZERO_BLANK_EN
    hp     = 3'd0;
    hp_vld = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (disp_point_q[i]) begin
        hp     = 3'(i);
        hp_vld = 1'b1;
      end
    end
    minus_pos = msd + 3'd1;
    blank     = (idx_q > msd) && (!hp_vld || (idx_q > hp));
`else
    minus_pos = 3'd5;
    blank     = 1'b0;
`endif
    cur_nib = disp_bcd_q[{idx_q, 2'b00} +: 4];
    if (minus_vld && (idx_q == minus_pos)) begin
      cur_code = 8'hBF;
    end else if (blank) begin
      cur_code = 8'hFF;
    end else begin
      case (cur_nib)
        4'd0:    cur_code = 8'hC0;
        4'd1:    cur_code = 8'hF9;
        4'd2:    cur_code = 8'hA4;
        4'd3:    cur_code = 8'hB0;
        4'd4:    cur_code = 8'h99;
        4'd5:    cur_code = 8'h92;
        4'd6:    cur_code = 8'h82;
        4'd7:    cur_code = 8'hF8;
        4'd8:    cur_code = 8'h80;
        4'd9:    cur_code = 8'h90;
        default: cur_code = 8'hFF;
      endcase
    end
    if (disp_point_q[idx_q]) cur_code[7] = 1'b0;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sel_q <= 6'd0;
      seg_q <= 8'hFF;
    end else if (bus.seg_en) begin
      sel_q <= 6'd1 << idx_q;
      seg_q <= cur_code;
    end else begin
      sel_q <= 6'd0;
      seg_q <= 8'hFF;
    end
  end

  assign bus.sel = sel_q;
  assign bus.seg = seg_q;

endmodule

// File: tb/tb_seg_scan_drv.sv
// Self-checking bench for seg_scan_drv: a scoreboard of expected display frames
// checked by a monitor, plus timed checks for blanking, re-trigger and reset.
module tb_seg_scan_drv;

  localparam logic [15:0] CNT = 16'd9;
  localparam int PER = 10;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  typedef struct {
    logic [47:0] codes;
    int          id;
  } frame_t;

  logic sys_clk = 1'b0;
  logic sys_rst;
  seg_scan_drv_if bus ();

  seg_scan_drv #(.CNT_MAX(CNT)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int frames_done = 0;
  frame_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] glyph(input int d);
    case (d)
      0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
      4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
      8: return 8'h80;  9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Reference: decimal digits by division, significance and sign rules from arithmetic.
  function automatic logic [7:0] model_code(input int unsigned value, input logic [5:0] pt,
                                            input bit sg, input int i);
    int unsigned v;
    int unsigned t;
    int unsigned p;
    int ndig;
    int hp;
    int mpos;
    logic [7:0] code;
    v = (value > 999999) ? 999999 : value;
    ndig = 1;
    t = v;
    while (t >= 10) begin
      t = t / 10;
      ndig++;
    end
    hp = -1;
    for (int k = 0; k < 6; k++) if (pt[k]) hp = k;
    mpos = -1;
    if (sg && ndig < 6) mpos = BLANK ? ndig : 5;
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (i == mpos)                          code = 8'hBF;
    else if (BLANK && i >= ndig && i > hp)  code = 8'hFF;
    else                                    code = glyph(int'((v / p) % 10));
    if (pt[i]) code[7] = 1'b0;
    return code;
  endfunction

  function automatic frame_t model_frame(input int unsigned value, input logic [5:0] pt,
                                         input bit sg, input int id);
    frame_t f;
    f.id = id;
    f.codes = '0;
    for (int i = 0; i < 6; i++) f.codes[8*i +: 8] = model_code(value, pt, sg, i);
    return f;
  endfunction

  function automatic int sel_index(input logic [5:0] s);
    int r;
    r = -1;
    for (int k = 0; k < 6; k++) if (s[k]) r = k;
    return r;
  endfunction

  // Monitor: for each expected frame, lock to digit 0 and walk all six digits.
  initial begin : monitor
    frame_t f;
    bit found;
    forever begin
      @(negedge sys_clk);
      if (sb_q.size() == 0) continue;
      f = sb_q.pop_front();
      found = 1'b0;
      for (int c = 0; c < 8 * PER; c++) begin
        if (bus.sel == 6'b000001) begin
          found = 1'b1;
          break;
        end
        @(negedge sys_clk);
      end
      check($sformatf("frame%0d_sync", f.id), 32'(found), 32'd1);
      if (found) begin
        for (int d = 0; d < 6; d++) begin
          if (d > 0) repeat (PER) @(negedge sys_clk);
          check($sformatf("frame%0d_sel%0d", f.id, d), 32'(bus.sel), 32'(6'd1 << d));
          check($sformatf("frame%0d_seg%0d", f.id, d), 32'(bus.seg), 32'(f.codes[8*d +: 8]));
        end
      end
      frames_done++;
    end
  end

  int unsigned cur_val;
  logic [5:0]  cur_pt;
  bit          cur_sg;

  task automatic apply_and_check(input int unsigned value, input logic [5:0] pt,
                                 input bit sg, input int id);
    int target;
    int c;
    @(negedge sys_clk);
    bus.data  = 20'(value);
    bus.point = pt;
    bus.sign  = sg;
    cur_val = value;
    cur_pt  = pt;
    cur_sg  = sg;
    repeat (30) @(negedge sys_clk);
    target = frames_done + 1;
    sb_q.push_back(model_frame(value, pt, sg, id));
    c = 0;
    while (frames_done < target && c < 20 * PER) begin
      @(negedge sys_clk);
      c++;
    end
    if (frames_done < target) check($sformatf("frame%0d_timeout", id), 32'd0, 32'd1);
  endtask

  // Wait until sel moves to a new non-zero digit (or to digit 0 when want0 is set).
  task automatic sync_digit_change(input bit want0, output int idx, output bit ok);
    logic [5:0] prev;
    ok = 1'b0;
    idx = -1;
    prev = bus.sel;
    for (int c = 0; c < 10 * PER; c++) begin
      @(negedge sys_clk);
      if (bus.sel != prev && bus.sel != 6'd0 && (!want0 || bus.sel == 6'b000001)) begin
        ok = 1'b1;
        idx = sel_index(bus.sel);
        break;
      end
      prev = bus.sel;
    end
    check("sync_digit", 32'(ok), 32'd1);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int idx;
    bit ok;
    int unsigned v;
    int exp_idx;
    bus.data   = 20'd0;
    bus.point  = 6'd0;
    bus.sign   = 1'b0;
    bus.seg_en = 1'b1;
    cur_val = 0;
    cur_pt  = 6'd0;
    cur_sg  = 1'b0;
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("reset_sel", 32'(bus.sel), 32'd0);
    check("reset_seg", 32'(bus.seg), 32'hFF);
    sys_rst = 1'b0;

    apply_and_check(0,       6'b000000, 1'b0, 0);
    apply_and_check(123456,  6'b000000, 1'b0, 1);
    apply_and_check(42,      6'b000000, 1'b1, 2);
    apply_and_check(1048575, 6'b000000, 1'b0, 3);
    apply_and_check(305,     6'b000100, 1'b0, 4);
    apply_and_check(0,       6'b000000, 1'b1, 5);
    apply_and_check(99999,   6'b100000, 1'b1, 6);
    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 3))
        0:       v = $urandom_range(0, 9);
        1:       v = $urandom_range(0, 9999);
        2:       v = $urandom_range(0, 999999);
        default: v = $urandom_range(0, 1048575);
      endcase
      apply_and_check(v, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 10 + n);
    end

    // Display off for 50 cycles: dark throughout, scanning keeps its pace.
    sync_digit_change(1'b0, idx, ok);
    if (ok) begin
      bus.seg_en = 1'b0;
      for (int c = 0; c < 50; c++) begin
        @(negedge sys_clk);
        check("dark_sel", 32'(bus.sel), 32'd0);
        check("dark_seg", 32'(bus.seg), 32'hFF);
      end
      bus.seg_en = 1'b1;
      @(negedge sys_clk);
      exp_idx = (idx + 5) % 6;
      check("resume_sel", 32'(bus.sel), 32'(6'd1 << exp_idx));
      check("resume_seg", 32'(bus.seg), 32'(model_code(cur_val, cur_pt, cur_sg, exp_idx)));
      repeat (PER) @(negedge sys_clk);
      check("resume_sel_next", 32'(bus.sel), 32'(6'd1 << idx));
      check("resume_seg_next", 32'(bus.seg), 32'(model_code(cur_val, cur_pt, cur_sg, idx)));
    end

    // Value changes mid-conversion: first result is 777, then 888 follows.
    sync_digit_change(1'b1, idx, ok);
    if (ok) begin
      bus.data  = 20'd777;
      bus.point = 6'd0;
      bus.sign  = 1'b0;
      for (int n = 1; n < 90; n++) begin
        @(negedge sys_clk);
        if (n == 6) bus.data = 20'd888;
        exp_idx = (n / PER) % 6;
        if (n >= 24 && n <= 29) begin
          check($sformatf("retrig777_sel_t%0d", n), 32'(bus.sel), 32'(6'd1 << exp_idx));
          check($sformatf("retrig777_seg_t%0d", n), 32'(bus.seg),
                32'(model_code(777, 6'd0, 1'b0, exp_idx)));
        end else if (n >= 50) begin
          check($sformatf("retrig888_sel_t%0d", n), 32'(bus.sel), 32'(6'd1 << exp_idx));
          check($sformatf("retrig888_seg_t%0d", n), 32'(bus.seg),
                32'(model_code(888, 6'd0, 1'b0, exp_idx)));
        end
      end
      cur_val = 888;
      cur_pt  = 6'd0;
      cur_sg  = 1'b0;
    end

    // Reset during a conversion: abandoned, then redone from the held input.
    @(negedge sys_clk);
    bus.data  = 20'd5555;
    bus.point = 6'b000010;
    bus.sign  = 1'b1;
    repeat (8) @(negedge sys_clk);
    sys_rst = 1'b1;
    #1;
    check("midreset_sel", 32'(bus.sel), 32'd0);
    check("midreset_seg", 32'(bus.seg), 32'hFF);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    apply_and_check(5555, 6'b000010, 1'b1, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_drv.md
SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

Interface
REQ-001 SHALL have parameter CNT_MAX, default 16'd49_999, per-digit scan period minus one in sys_clk cycles (1 ms at 50 MHz).
REQ-002 SHALL have port sys_clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port data  input  20  unsigned binary value to display.
REQ-005 SHALL have port point  input  6  decimal-point enables; bit i lights the dp of digit i (digit 0 rightmost).
REQ-006 SHALL have port sign  input  1  1 = display a minus sign.
REQ-007 SHALL have port seg_en  input  1  1 = display on; 0 = all digits dark.
REQ-008 SHALL have port sel  output  6  one-hot active-high digit select, registered.
REQ-009 SHALL have port seg  output  8  active-low segments {dp,g,f,e,d,c,b,a}, registered.

Function
REQ-010 SHALL run the scan counter 0..CNT_MAX, wrapping to 0; at each wrap the digit index SHALL advance 0,1,...,5,0.
REQ-011 SHALL drive sel = 1 << digit index and seg = the code of that digit, both updated one cycle after the index changes.
REQ-012 SHALL encode digits as 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90, minus BF, blank FF (hex); a set point bit SHALL clear seg[7].
REQ-013 SHALL convert binary to BCD with a sequential shift-add-3 FSM: IDLE -> SHIFT (exactly 20 cycles) -> DONE (1 cycle) -> IDLE.
REQ-014 SHALL leave IDLE when data differs from the last converted value; it SHALL sample data, point and sign on that cycle.
REQ-015 SHALL load the six display digits, point and sign into the display registers in DONE, 22 cycles after the sample; display is glitch-free meanwhile.
REQ-016 SHALL ignore data changes during SHIFT/DONE; a differing value still present on return to IDLE SHALL start a new conversion.
REQ-017 SHALL saturate data > 999_999 to 999_999 before conversion.
REQ-018 SHALL, when sign = 1 and the value has at most 5 significant digits, show minus on the digit directly left of the most significant digit; with 6 significant digits sign SHALL be ignored.
REQ-019 SHALL, when seg_en = 0, force sel = 6'b000000 and seg = 8'hFF while scanning and conversion continue.
REQ-020 SHALL treat data = 0 as one significant digit (digit 0 shows 0).

Reset
REQ-021 SHALL on sys_rst = 1 asynchronously set sel = 0, seg = 8'hFF, scan counter = 0, digit index = 0, FSM = IDLE, BCD and display registers = 0, last-converted value = 0.
REQ-022 SHALL, on reset asserted mid-conversion, abandon it; after release the current data SHALL be converted afresh if non-zero.

Configuration
REQ-023 SHALL honour macro LEADING_ZERO_BLANK_EN: when defined, digits above the most significant digit and above the highest set point bit SHALL show blank (FF) except the minus position.
REQ-024 SHALL, without LEADING_ZERO_BLANK_EN, show all six digits including leading zeros, and with sign = 1 and at most 5 significant digits SHALL show minus on digit 5.

Verification
REQ-025 SHALL verify: CNT_MAX=9, reset release, seg_en=1, data=123456 -> after 22 cycles sel walks 01,02,04,08,10,20 every 10 cycles with seg 82,92,99,B0,A4,F9.
REQ-026 SHALL verify: blanking on, data=42, sign=1 -> digit0 99, digit1 A4, digit2 BF, digits3-5 FF.
REQ-027 SHALL verify: data=1_048_575 -> all six digits show 90 (saturated 999999).
REQ-028 SHALL verify: data=305, point=6'b000100 -> digit2 shows 30 (3 with dp), digit1 C0, digit0 92.
REQ-029 SHALL verify: seg_en=0 for 50 cycles -> sel=00, seg=FF throughout; on seg_en=1 scan resumes at the current index.
REQ-030 SHALL verify: data changed 777 -> 888 on SHIFT cycle 5, held -> display shows 777 after first DONE, 888 after 22 further cycles plus IDLE re-entry.
